sd_wide2narrow: RTL and testbench
=================================

// Module: sd_wide2narrow
// PURPOSE
//  - Srdy/drdy width serializer placed directly downstream of sd_fifo_tailwr (or any sd FIFO).
//  - Accepts one wide word per handshake and emits it as 1..RATIO narrow beats on the p_ side.
//  - The number of beats per word is set per word by c_last_idx.
//  - Full throughput: a new word is accepted in the same cycle the last beat of the previous word leaves.
// PARAMETERS
//  width    32  input word width; must equal nwidth*RATIO
//  nwidth   8   output beat width
//  lsb_first 1  1: beat 0 = c_data[nwidth-1:0]; 0: beat 0 = c_data[width-1 -: nwidth]
//  (localparam RATIO = width/nwidth, must be >= 2; isz = $clog2(RATIO))
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  c_srdy      in   1       upstream word valid
//  c_drdy      out  1       ready to take a word
//  c_data      in   width   wide word
//  c_last_idx  in   isz     index of last valid beat (0 = one beat, RATIO-1 = all beats)
//  p_srdy      out  1       beat valid
//  p_drdy      in   1       downstream ready
//  p_data      out  nwidth  current beat
//  p_last      out  1       current beat is last of its word
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high.
//  - State:
//    - valid (hold register occupied)
//    - hold[width-1:0]
//    - last[isz-1:0]
//    - cnt[isz-1:0] (current beat index)
//  - Reset values:
//    - valid=0, cnt=0, hold=0, last=0
//    - hence p_srdy=0, p_data=0, p_last=0, c_drdy=1 in the first cycle after reset.
//  - Outputs are registered-state driven, no comb path from c_srdy to p_srdy:
//    - p_srdy = valid
//    - p_data = beat cnt of hold
//    - p_last = valid & (cnt==last)
//  - c_drdy = !valid | (p_drdy & p_last). This is the only comb path (p_drdy -> c_drdy).
//  - Load (c_srdy & c_drdy): hold<=c_data, last<=c_last_idx, cnt<=0, valid<=1.
//    First beat appears on p_ the cycle after acceptance (latency 1).
//  - Beat transfer (p_srdy & p_drdy):
//    - not last: cnt<=cnt+1
//    - last: if a load occurs in the same cycle, the load wins (back-to-back, no bubble); otherwise valid<=0, cnt<=0.
//  - Stall (p_srdy & !p_drdy): hold, cnt, p_data and p_last remain stable.
//  - Never drop, repeat or reorder beats; beats beyond last are never emitted.
//  - States:
//    - EMPTY (valid=0) -> LOADED on load.
//    - LOADED -> LOADED on a non-last beat transfer, or on a last beat with a simultaneous load.
//    - LOADED -> EMPTY on a last beat with no load.
//  - c_last_idx > RATIO-1 cannot occur: the field width is isz and RATIO is a power of 2.
//    The RTL asserts RATIO==2**isz in simulation.
//  - Reset asserted mid-word: the partial word is discarded; p_srdy=0 on the next cycle.
// STRUCTURE
//  - Add the sd_beat_idx_t typedef (isz-wide, parameterised via sdlib_pkg) and the
//    lsb_first/msb_first beat-select constants to sdlib_pkg.
//  - Single module, no sub-module: hold/cnt control plus a beat mux (case on cnt, or an indexed part-select).
// TESTING  (width=32, nwidth=8, lsb_first=1)
//  1. Reset held 5 cycles, then released -> p_srdy=0, p_last=0, c_drdy=1; usage of the upstream FIFO unchanged.
//  2. Word 0x44332211, last_idx=3, p_drdy=1 -> beats 11,22,33,44 on 4 consecutive cycles; p_last only on 44.
//  3. Two words 0x44332211, 0x88776655 back-to-back, p_drdy=1 -> 8 beats with no gap;
//     c_drdy=1 only in the cycle of beat 44.
//  4. Word 0xAABBCCDD, last_idx=1 -> beats DD, CC with p_last on CC; next word loads in the same cycle.
//  5. p_drdy driven by pattern 0x5A while c_srdy=1 -> p_data/p_last stable during stalls;
//     output sequence identical to case 3.
//  6. Chain sd_seq_gen(32b) -> sd_fifo_tailwr(depth 7) -> this -> beat reassembler -> sd_seq_check.
//     Random srdy/drdy patterns for 9000 words: ok_cnt >= 1000, no mismatch.
//     Also assert reset at beat 2 -> p_srdy=0 next cycle.

Source files
------------

// File: rtl/sdlib_pkg.sv
// Shared srdy/drdy library types: default serializer geometry, beat index type,
// beat-order select constants and the serializer occupancy state.
package sdlib_pkg;

    localparam int SD_WIDTH  = 32;
    localparam int SD_NWIDTH = 8;
    localparam int SD_RATIO  = SD_WIDTH / SD_NWIDTH;
    localparam int SD_ISZ    = $clog2(SD_RATIO);

    typedef logic [SD_ISZ-1:0] sd_beat_idx_t;

    localparam bit SD_LSB_FIRST = 1'b1;
    localparam bit SD_MSB_FIRST = 1'b0;

    typedef enum logic {
        SD_W2N_EMPTY  = 1'b0,
        SD_W2N_LOADED = 1'b1
    } sd_w2n_state_e;

endpackage

// File: rtl/sd_wide2narrow.sv
// Srdy/drdy width serializer: takes one wide word and emits 1..RATIO narrow beats,
// with the beat count chosen per word by c_last_idx.
module sd_wide2narrow
    import sdlib_pkg::*;
#(
    parameter int   width     = SD_WIDTH,
    parameter int   nwidth    = SD_NWIDTH,
    parameter bit   lsb_first = SD_LSB_FIRST,
    localparam int  RATIO     = width / nwidth,
    localparam int  isz       = $clog2(RATIO)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_srdy,
    output logic              c_drdy,
    input  logic [width-1:0]  c_data,
    input  logic [isz-1:0]    c_last_idx,
    output logic              p_srdy,
    input  logic              p_drdy,
    output logic [nwidth-1:0] p_data,
    output logic              p_last
);

    if (RATIO < 2 || RATIO != (1 << isz) || width != nwidth * RATIO) begin : g_bad_geometry
        $error("sd_wide2narrow: width must be nwidth*RATIO with RATIO a power of 2 >= 2");
    end

    localparam logic [isz-1:0] MAX_IDX = isz'(RATIO - 1);

    sd_w2n_state_e    state_q, state_d;
    logic [width-1:0] hold_q,  hold_d;
    logic [isz-1:0]   last_q,  last_d;
    logic [isz-1:0]   cnt_q,   cnt_d;

    logic             valid;
    logic [isz-1:0]   beat_sel;
    logic             c_load;
    logic             p_xfer;

    always_comb begin
        valid    = (state_q == SD_W2N_LOADED);
        beat_sel = lsb_first ? cnt_q : (MAX_IDX - cnt_q);
        p_srdy   = valid;
        p_data   = hold_q[int'(beat_sel) * nwidth +: nwidth];
        p_last   = valid && (cnt_q == last_q);
        // p_drdy -> c_drdy is the only combinational path through the block.
        c_drdy   = !valid || (p_drdy && p_last);
        c_load   = c_srdy && c_drdy;
        p_xfer   = p_srdy && p_drdy;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (p_xfer) begin
            if (p_last) begin
                state_d = SD_W2N_EMPTY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A load overrides the retire of a finishing word, giving back-to-back words.
        if (c_load) begin
            state_d = SD_W2N_LOADED;
            hold_d  = c_data;
            last_d  = c_last_idx;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SD_W2N_EMPTY;
            hold_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sd_wide2narrow.sv
// Randomized bench for sd_wide2narrow (32 -> 8, lsb first) against a beat-queue
// reference model: pending beats of the held word live in a queue.
module tb_sd_wide2narrow;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_srdy;
    logic        c_drdy;
    logic [31:0] c_data;
    logic [1:0]  c_last_idx;
    logic        p_srdy;
    logic        p_drdy;
    logic [7:0]  p_data;
    logic        p_last;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned beats    = 0;

    // Each entry is {last_flag, beat_data}; size() is the number of beats still owed.
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    sd_wide2narrow #(
        .width    (32),
        .nwidth   (8),
        .lsb_first(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c_srdy    (c_srdy),
        .c_drdy    (c_drdy),
        .c_data    (c_data),
        .c_last_idx(c_last_idx),
        .p_srdy    (p_srdy),
        .p_drdy    (p_drdy),
        .p_data    (p_data),
        .p_last    (p_last)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic cycle(input logic rs, input logic cs, input logic [31:0] d,
                         input logic [1:0] li, input logic pd);
        logic       exp_valid;
        logic       exp_cdrdy;
        logic [8:0] head;
        reset      = rs;
        c_srdy     = cs;
        c_data     = d;
        c_last_idx = li;
        p_drdy     = pd;
        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        head      = exp_valid ? exp_q[0] : 9'h0;
        exp_cdrdy = !exp_valid || (pd && exp_q.size() == 1);
        check_val("p_srdy", 32'(p_srdy), 32'(exp_valid));
        check_val("c_drdy", 32'(c_drdy), 32'(exp_cdrdy));
        check_val("p_last", 32'(p_last), 32'(exp_valid && head[8]));
        if (exp_valid)
            check_val("p_data", 32'(p_data), 32'(head[7:0]));
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
        end else begin
            if (exp_valid && pd) begin
                void'(exp_q.pop_front());
                beats++;
            end
            if (cs && exp_cdrdy) begin
                for (int unsigned i = 0; i <= 32'(li); i++)
                    exp_q.push_back({i == 32'(li), d[i*8 +: 8]});
            end
        end
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        reset = 1'b1; c_srdy = 1'b0; c_data = '0; c_last_idx = '0; p_drdy = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 2'd0, 1'b0);

        // Reset state, sampled before any input is applied.
        check_val("rst_p_srdy", 32'(p_srdy), 32'h0);
        check_val("rst_p_last", 32'(p_last), 32'h0);
        check_val("rst_p_data", 32'(p_data), 32'h0);
        check_val("rst_c_drdy", 32'(c_drdy), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

        // Single full word, free-running sink.
        cycle(1'b0, 1'b1, 32'h44332211, 2'd3, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

        // Back-to-back words; the second word offered continuously until taken.
        cycle(1'b0, 1'b1, 32'h44332211, 2'd3, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h88776655, 2'd3, 1'b1);
        // Short word followed immediately by a one-beat word.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'hAABBCCDD, 2'd1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 32'h000000EE, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

        // Stalls from a 0x5A ready pattern with upstream always offering.
        pat = 8'h5A;
        for (int i = 0; i < 24; i++)
            cycle(1'b0, 1'b1, (i < 12) ? 32'h44332211 : 32'h88776655, 2'd3, pat[i % 8]);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

        // Reset mid-word: partial word discarded.
        cycle(1'b0, 1'b1, 32'hCAFEF00D, 2'd3, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
        check_val("midrst_p_srdy", 32'(p_srdy), 32'h0);
        check_val("midrst_c_drdy", 32'(c_drdy), 32'h1);

        // Random traffic, random lengths, occasional reset.
        for (int i = 0; i < 6000; i++) begin
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), $urandom(),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        check_val("drained", 32'(exp_q.size()), 32'h0);
        check_val("beats_seen", 32'(beats > 1000), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
